// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer; owns the fetch PC and hands instructions to decode.
//   clk, rst                      clock, async active-high reset
//   imem_req/imem_addr            request valid (REQ only) and word-aligned fetch address
//   imem_gnt/imem_rvalid/rdata    memory grant, response valid and instruction word
//   redirect_valid/redirect_pc    single-cycle PC redirect from later stages
//   if_valid/if_instr/if_pc       registered instruction presented to decode
//   id_ready                      decode accepts when if_valid & id_ready
//   fetch_count                   instructions handed to decode, wraps mod 2^32
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, if_instr_q, if_instr_d, if_pc_q, if_pc_d, count_q, count_d;
  logic        kill_q, kill_d, if_valid_q, if_valid_d;
  logic [31:0] redir_pc;
  assign redir_pc    = redirect_pc & ~32'h3;
  assign imem_req    = state_q == REQ;
  assign imem_addr   = fetch_pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_count = count_q;
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    count_d    = count_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        // a grant in the redirect cycle belongs to the old address, so its response is killed
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          kill_d     = imem_gnt;
          state_d    = imem_gnt ? WAIT : REQ;
        end else if (imem_gnt) begin
          kill_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid && (kill_q || redirect_valid)) begin
          fetch_pc_d = redirect_valid ? redir_pc : fetch_pc_q;
          kill_d     = 1'b0;
          state_d    = REQ;
        end else if (imem_rvalid) begin
          if_instr_d = imem_rdata;
          if_pc_d    = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          if_valid_d = 1'b1;
          state_d    = HOLD;
        end else if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          kill_d     = 1'b1;
        end
      end
      HOLD: begin
        // a redirect squashes the held instruction even if decode is ready
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          fetch_pc_d = redir_pc;
          state_d    = REQ;
        end else if (id_ready) begin
          if_valid_d = 1'b0;
          count_d    = count_q + 32'd1;
          state_d    = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven, directed and randomized checks of fetch_ctrl.
module tb_fetch_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        gnt = 1'b0, rvalid = 1'b0, redir = 1'b0, rdy = 1'b0;
  logic [31:0] rdata = '0, rpc = '0;
  logic        req, ifv, h_req, h_ifv;
  logic [31:0] addr, instr, ipc, cnt, h_addr, h_instr, h_ipc, h_cnt;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .redirect_valid(redir), .redirect_pc(rpc),
    .if_valid(ifv), .if_instr(instr), .if_pc(ipc), .id_ready(rdy), .fetch_count(cnt)
  );
  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst(rst), .imem_req(h_req), .imem_addr(h_addr), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .redirect_valid(redir), .redirect_pc(rpc),
    .if_valid(h_ifv), .if_instr(h_instr), .if_pc(h_ipc), .id_ready(rdy), .fetch_count(h_cnt)
  );
  typedef struct {
    logic g, rv; logic [31:0] rdata; logic rd; logic [31:0] rpc; logic rdy;
    logic req; logic [31:0] addr; logic ifv; logic [31:0] instr, ipc, cnt, addr2;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic outs(input string n, input logic r, input logic [31:0] ad, input logic v,
                      input logic [31:0] in, input logic [31:0] pc, input logic [31:0] c);
    chk({n, ".req"}, {31'd0, req}, {31'd0, r});
    chk({n, ".addr"}, addr, ad);
    chk({n, ".ifv"}, {31'd0, ifv}, {31'd0, v});
    chk({n, ".instr"}, instr, in);
    chk({n, ".ipc"}, ipc, pc);
    chk({n, ".cnt"}, cnt, c);
  endtask
  task automatic drive(input logic g, input logic rv, input logic [31:0] d, input logic rd,
                       input logic [31:0] p, input logic r);
    gnt = g; rvalid = rv; rdata = d; redir = rd; rpc = p; rdy = r;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    gnt = 0; rvalid = 0; redir = 0; rdy = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  // reference model: transaction view of the fetch stage
  logic        m_started, m_busy, m_stale, m_have;
  logic [31:0] m_pc, m_cnt, m_instr, m_ipc;
  int          rem;
  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFFC};
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFFC};
    tbl[2]  = '{1, 1, 32'h1111_0000, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFFC};
    tbl[3]  = '{1, 0, 0, 0, 0, 1, 0, 32'h4, 1, 32'h1111_0000, 32'h0, 0, 32'h0};
    tbl[4]  = '{1, 0, 0, 0, 0, 1, 1, 32'h4, 0, 32'h1111_0000, 32'h0, 1, 32'h0};
    tbl[5]  = '{1, 1, 32'h2222_0004, 0, 0, 1, 0, 32'h4, 0, 32'h1111_0000, 32'h0, 1, 32'h0};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, 32'h8, 1, 32'h2222_0004, 32'h4, 1, 32'h4};
    tbl[7]  = '{1, 0, 0, 0, 0, 1, 1, 32'h8, 0, 32'h2222_0004, 32'h4, 2, 32'h4};
    tbl[8]  = '{1, 1, 32'h3333_0008, 0, 0, 1, 0, 32'h8, 0, 32'h2222_0004, 32'h4, 2, 32'h4};
    tbl[9]  = '{1, 0, 0, 0, 0, 1, 0, 32'hC, 1, 32'h3333_0008, 32'h8, 2, 32'h8};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 1, 32'hC, 0, 32'h3333_0008, 32'h8, 3, 32'h8};
    @(negedge clk);
    @(negedge clk);
    outs("reset", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    chk("reset.addr_hi", h_addr, 32'hFFFF_FFFC);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      outs($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr, tbl[i].ifv, tbl[i].instr, tbl[i].ipc, tbl[i].cnt);
      chk($sformatf("tbl%0d.addr_hi", i), h_addr, tbl[i].addr2);
      drive(tbl[i].g, tbl[i].rv, tbl[i].rdata, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
    end
    // stall in HOLD for 5 cycles (state REQ at 0xC, count 3)
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h5555_5555, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      outs($sformatf("stall%0d", i), 0, 32'h10, 1, 32'h5555_5555, 32'hC, 32'd3);
      drive(0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    outs("stall_rel", 1, 32'h10, 0, 32'h5555_5555, 32'hC, 32'd4);
    // redirect in WAIT one cycle before the response
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h103, 0);
    outs("wredir", 0, 32'h100, 0, 32'h5555_5555, 32'hC, 32'd4);
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 1);
    outs("wredir_drop", 1, 32'h100, 0, 32'h5555_5555, 32'hC, 32'd4);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h0000_1234, 0, 0, 0);
    outs("wredir_dlv", 0, 32'h104, 1, 32'h0000_1234, 32'h100, 32'd4);
    drive(0, 0, 0, 0, 0, 1);
    outs("wredir_acc", 1, 32'h104, 0, 32'h0000_1234, 32'h100, 32'd5);
    // redirect coinciding with grant in REQ
    drive(0, 0, 0, 1, 32'h20, 0);
    outs("rq_move", 1, 32'h20, 0, 32'h0000_1234, 32'h100, 32'd5);
    drive(1, 0, 0, 1, 32'h80, 0);
    outs("rq_gnt", 0, 32'h80, 0, 32'h0000_1234, 32'h100, 32'd5);
    drive(0, 1, 32'h0BAD_0020, 0, 0, 1);
    outs("rq_drop", 1, 32'h80, 0, 32'h0000_1234, 32'h100, 32'd5);
    // redirect in HOLD while decode is ready
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h0000_0777, 0, 0, 0);
    outs("hold", 0, 32'h84, 1, 32'h0000_0777, 32'h80, 32'd5);
    drive(0, 0, 0, 1, 32'h200, 1);
    outs("hold_sq", 1, 32'h200, 0, 32'h0000_0777, 32'h80, 32'd5);
    // async reset while in WAIT, then stray responses
    drive(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    outs("arst", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 32'h999, 0, 0, 1);
    outs("stray_boot", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    drive(0, 1, 32'h998, 0, 0, 1);
    outs("stray_req", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    // randomized run against the model
    do_reset();
    m_started = 0; m_busy = 0; m_stale = 0; m_have = 0;
    m_pc = 0; m_cnt = 0; m_instr = 0; m_ipc = 0; rem = 0;
    for (int c = 0; c < 3000; c++) begin
      logic g, rv, rd, r, was_req, was_busy;
      logic [31:0] d, p;
      outs("rand", m_started && !m_busy && !m_have, m_pc, m_have, m_instr, m_ipc, m_cnt);
      g = 1'($urandom % 2);
      rv = m_busy ? (rem == 0) : ($urandom % 8 == 0);
      rd = ($urandom % 6 == 0);
      r = ($urandom % 3 != 0);
      d = $urandom;
      p = $urandom;
      was_req = m_started && !m_busy && !m_have;
      was_busy = m_busy;
      if (!m_started) m_started = 1;
      else if (m_have) begin
        if (rd) begin m_have = 0; m_pc = p & ~32'h3; end
        else if (r) begin m_have = 0; m_cnt = m_cnt + 1; end
      end else if (m_busy) begin
        if (rv) begin
          m_busy = 0;
          if (m_stale || rd) begin
            if (rd) m_pc = p & ~32'h3;
            m_stale = 0;
          end else begin
            m_instr = d; m_ipc = m_pc; m_pc = m_pc + 4; m_have = 1;
          end
        end else if (rd) begin m_pc = p & ~32'h3; m_stale = 1; end
      end else begin
        if (rd) m_pc = p & ~32'h3;
        if (g) begin m_busy = 1; m_stale = rd; end
      end
      if (was_req && g) rem = $urandom_range(0, 2);
      else if (was_busy && !rv) rem--;
      drive(g, rv, d, rd, p, r);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage.
- Owns the fetch PC and issues one instruction-memory request at a time over a req/gnt + rvalid handshake.
- Presents each fetched instruction to decode over a valid/ready handshake, and redirects the PC on branch/jump/flush from later stages.
- Replaces the free-running PC increment: the PC now advances only when an instruction is actually delivered.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req  output  1  request valid; high only in state REQ
- imem_addr  output  32  word-aligned fetch address (= fetch_pc)
- imem_gnt  input  1  memory accepts request this cycle (meaningful only while imem_req=1)
- imem_rvalid  input  1  read data valid; at most one per granted request, at least 1 cycle after gnt
- imem_rdata  input  32  instruction word
- redirect_valid  input  1  single-cycle PC redirect from EX/commit
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0 internally
- if_valid  output  1  instruction available to decode
- if_instr  output  32  instruction word
- if_pc  output  32  address of if_instr
- id_ready  input  1  decode accepts instruction when if_valid & id_ready
- fetch_count  output  32  number of instructions handed to decode, wraps mod 2^32

Behaviour:
- Reset values (async, immediate):
  - state=BOOT, fetch_pc=RESET_PC, kill=0
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0, fetch_count=0
- Outputs:
  - imem_req and imem_addr are decoded from state/fetch_pc.
  - All other outputs are registered.
- States: BOOT, REQ, WAIT, HOLD.
- BOOT: unconditionally -> REQ next cycle. Redirect is ignored in BOOT.
- REQ: imem_req=1, imem_addr=fetch_pc. Rules in priority order:
  - redirect_valid & imem_gnt: the granted transfer belongs to the old address. Set fetch_pc=redirect_pc, kill=1, -> WAIT.
  - redirect_valid & !imem_gnt: set fetch_pc=redirect_pc, stay REQ. The address may change only while not granted.
  - imem_gnt: -> WAIT, kill=0.
- WAIT: waiting for rvalid. Rules in priority order:
  - imem_rvalid & (kill | redirect_valid): discard data. If redirect_valid, fetch_pc=redirect_pc. Then kill=0, -> REQ.
  - imem_rvalid: if_instr=imem_rdata, if_pc=fetch_pc, fetch_pc=fetch_pc+4, if_valid=1, -> HOLD.
  - redirect_valid without rvalid: fetch_pc=redirect_pc, kill=1, stay WAIT. A second redirect overwrites the first.
- HOLD: if_valid=1; if_instr and if_pc are stable until they leave HOLD. Rules in priority order:
  - redirect_valid: if_valid=0, fetch_pc=redirect_pc, -> REQ. The instruction is squashed even if id_ready=1; fetch_count is not incremented.
  - id_ready: transfer completes. if_valid=0, fetch_count+=1, -> REQ.
- Arithmetic: fetch_pc+4 is 32-bit modulo, so 32'hFFFF_FFFC -> 32'h0000_0000. fetch_count wraps to 0 after 32'hFFFF_FFFF.
- Stray rvalid: imem_rvalid outside WAIT is ignored, and no state changes.
- Reset mid-transaction: all state returns to reset values. The memory shares rst, so no response from a pre-reset request is expected.
- Throughput: with gnt in the request cycle and rvalid 1 cycle later, one instruction per 3 cycles (REQ, WAIT, HOLD with id_ready=1).
- Delivery latency: 2 cycles from the REQ cycle to if_valid=1.
- First request: imem_req=1 in the 2nd cycle after rst deasserts.

Test Plan:
- Reset release, gnt=1 immediately, rvalid 1 cycle after gnt, id_ready=1 -> addresses 0x0,0x4,0x8 issued 3 cycles apart; if_pc matches each address; fetch_count=3 after third handshake.
- id_ready=0 for 5 cycles in HOLD -> if_valid/if_instr/if_pc held constant; no imem_req; no count change; fetch proceeds on first id_ready=1.
- redirect_pc=0x103 asserted in WAIT 1 cycle before rvalid(data 0xDEADBEEF) -> data discarded, if_valid stays 0; next imem_addr=0x100; if_pc=0x100 on delivery.
- redirect and gnt same cycle in REQ (old addr 0x20, target 0x80) -> response for 0x20 dropped; next request address 0x80.
- Redirect with id_ready=1 in HOLD -> if_valid falls; fetch_count unchanged; next imem_addr = redirect target.
- RESET_PC=0xFFFF_FFFC -> second request address 0x0000_0000. Assert rst while in WAIT -> outputs at reset values asynchronously; a stray rvalid after release is ignored.
